// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int RF_MIN_DEPTH = 2;
    localparam int RF_MAX_NRD   = 4;

    // Word-address width for a given depth, never narrower than one bit.
    function automatic int rf_aw(input int depth);
        return (depth < RF_MIN_DEPTH) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: zero/bypass/array priority select with an optional output register.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int AW      = 5,
    parameter int RD_REG  = 0,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  rf_state_e        state,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] rf_word,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] sel_data;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_data = rf_word;
        if (state == RF_CLEAR) begin
            sel_data = '0;
        end else if (ZERO_R0 != 0 && addr == '0) begin
            sel_data = '0;
        end else if (BYPASS != 0 && wen && addr == waddr) begin
            sel_data = wdata;
        end
    end

    generate
        if (RD_REG != 0) begin : g_reg
            logic [WIDTH-1:0] data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                end else begin
                    data_q <= sel_data;
                end
            end

            assign data = data_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = ^{clk, rst};
            assign data = sel_data;
        end
    endgenerate

    // Bypass inputs go unread when BYPASS=0.
    logic unused_bypass;
    assign unused_bypass = ^{wen, waddr, wdata};

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one synchronous write port, NRD read ports,
// and a post-reset sequencer that zeroes every entry before accepting writes.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 32,
    parameter  int NRD     = 2,
    parameter  int RD_REG  = 0,
    parameter  int BYPASS  = 1,
    parameter  int ZERO_R0 = 1,
    localparam int AW      = rf_aw(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen,
    input  logic [AW-1:0]              waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [NRD-1:0][AW-1:0]     raddr,
    output logic [NRD-1:0][WIDTH-1:0]  rdata,
    output logic                       init_busy,
    output logic                       wr_drop
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

    rf_state_e        state;
    logic [AW-1:0]    clr_ptr;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RF_CLEAR;
            clr_ptr   <= '0;
            init_busy <= 1'b1;
            wr_drop   <= 1'b0;
        end else begin
            wr_drop <= (state == RF_CLEAR) && wen;
            if (state == RF_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_ptr == LAST_ADDR) begin
                    state     <= RF_READY;
                    init_busy <= 1'b0;
                end
            end
        end
    end

    // The clear sequencer owns the single write port until READY.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = waddr;
        mem_wd = wdata;
        if (!rst) begin
            if (state == RF_CLEAR) begin
                mem_we = 1'b1;
                mem_wa = clr_ptr;
                mem_wd = '0;
            end else if (wen && !(ZERO_R0 != 0 && waddr == '0)) begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: the array has no reset so it maps to distributed RAM; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [WIDTH-1:0] rf_word;
            assign rf_word = mem[raddr[i]];

            regfile_rdport #(
                .WIDTH   (WIDTH),
                .AW      (AW),
                .RD_REG  (RD_REG),
                .BYPASS  (BYPASS),
                .ZERO_R0 (ZERO_R0)
            ) u_rdport (
                .clk     (clk),
                .rst     (rst),
                .state   (state),
                .addr    (raddr[i]),
                .rf_word (rf_word),
                .wen     (wen),
                .waddr   (waddr),
                .wdata   (wdata),
                .data    (rdata[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench: three regfile_mp configurations driven with directed vectors and a small reference model.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // a: async read, bypass, zero r0.  b: registered read, no bypass, no zero r0.
    logic             rst;
    logic             wen;
    logic [4:0]       waddr;
    logic [31:0]      wdata;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rdata_a, rdata_b;
    logic             busy_a, busy_b, drop_a, drop_b;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .RD_REG(0), .BYPASS(1), .ZERO_R0(1)) dut_a (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_a), .init_busy(busy_a), .wr_drop(drop_a));

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .RD_REG(1), .BYPASS(0), .ZERO_R0(0)) dut_b (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_b), .init_busy(busy_b), .wr_drop(drop_b));

    // c: wide configuration, checked against a reference array.
    logic             c_rst;
    logic             c_wen;
    logic [5:0]       c_waddr;
    logic [15:0]      c_wdata;
    logic [3:0][5:0]  c_raddr;
    logic [3:0][15:0] c_rdata;
    logic             c_busy, c_drop;
    logic [15:0]      ref_c [64];

    regfile_mp #(.WIDTH(16), .DEPTH(64), .NRD(4), .RD_REG(0), .BYPASS(1), .ZERO_R0(1)) dut_c (
        .clk(clk), .rst(c_rst), .wen(c_wen), .waddr(c_waddr), .wdata(c_wdata), .raddr(c_raddr),
        .rdata(c_rdata), .init_busy(c_busy), .wr_drop(c_drop));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs the clear sequence for a/b, optionally issuing one write on cycle wr_cycle.
    task automatic run_clear(input int wr_cycle, output int busy_n, output int drop_n, output int drop_at);
        busy_n  = 0;
        drop_n  = 0;
        drop_at = -1;
        for (int k = 0; k < 200; k++) begin
            if (k == wr_cycle) begin
                wen = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
            end else begin
                wen = 1'b0;
            end
            if (!busy_a) break;
            busy_n++;
            if (k == 2) begin
                check("clear_rdata_a", rdata_a[0], 32'h0);
                check("clear_rdata_b", rdata_b[1], 32'h0);
            end
            @(posedge clk); #1;
            if (drop_a) begin
                drop_n++;
                drop_at = k;
            end
        end
        wen = 1'b0;
    endtask

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0, ra1;
        logic [31:0] ea0, ea1, eb0, eb1;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int busy_n, drop_n, drop_at, c_busy_n;
        logic [31:0] prev_b0, prev_b1;
        logic [15:0] exp_c;

        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        c_rst = 1'b1; c_wen = 1'b0; c_waddr = '0; c_wdata = '0; c_raddr = '0;

        //                wen waddr wdata         ra0 ra1  ea0           ea1           eb0           eb1
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd1,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd7,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[6] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd30, 32'h1,        32'h0,        32'h0,        32'h0};
        vecs[7] = '{1'b1, 5'd31, 32'h00000002, 5'd31, 5'd31, 32'h2,        32'h2,        32'h1,        32'h1};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'h2,        32'hDEADBEEF, 32'h2,        32'hDEADBEEF};

        // Reset state.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_busy_a", 32'(busy_a), 32'h1);
        check("rst_busy_b", 32'(busy_b), 32'h1);
        check("rst_drop_a", 32'(drop_a), 32'h0);
        check("rst_rdata_b", rdata_b[0], 32'h0);

        // Reset release: busy for exactly DEPTH cycles, then everything reads 0.
        rst = 1'b0;
        raddr[0] = 5'd5; raddr[1] = 5'd9;
        run_clear(-1, busy_n, drop_n, drop_at);
        check("init_cycles", 32'(busy_n), 32'd32);
        check("init_busy_b_low", 32'(busy_b), 32'h0);
        check("init_no_drop", 32'(drop_n), 32'h0);

        for (int a = 0; a < 32; a++) begin
            raddr[0] = 5'(a); raddr[1] = 5'(31 - a);
            #1;
            check("zero_a0", rdata_a[0], 32'h0);
            check("zero_a1", rdata_a[1], 32'h0);
            @(posedge clk); #1;
            check("zero_b0", rdata_b[0], 32'h0);
            check("zero_b1", rdata_b[1], 32'h0);
        end

        // Directed table: async outputs before the edge, registered outputs after it.
        prev_b0 = 32'h0; prev_b1 = 32'h0;
        for (int i = 0; i < 9; i++) begin
            wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr[0] = vecs[i].ra0; raddr[1] = vecs[i].ra1;
            #1;
            check($sformatf("vec%0d_a0", i), rdata_a[0], vecs[i].ea0);
            check($sformatf("vec%0d_a1", i), rdata_a[1], vecs[i].ea1);
            check($sformatf("vec%0d_b0_hold", i), rdata_b[0], prev_b0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_b0", i), rdata_b[0], vecs[i].eb0);
            check($sformatf("vec%0d_b1", i), rdata_b[1], vecs[i].eb1);
            check($sformatf("vec%0d_drop", i), 32'(drop_a), 32'h0);
            prev_b0 = vecs[i].eb0; prev_b1 = vecs[i].eb1;
        end
        wen = 1'b0;

        // Write during clear: single drop pulse, entry stays 0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_clear(3, busy_n, drop_n, drop_at);
        check("clrwr_cycles", 32'(busy_n), 32'd32);
        check("clrwr_drop_count", 32'(drop_n), 32'd1);
        check("clrwr_drop_cycle", 32'(drop_at), 32'd3);
        raddr[0] = 5'd3; raddr[1] = 5'd3;
        #1;
        check("clrwr_addr3_a", rdata_a[0], 32'h0);
        @(posedge clk); #1;
        check("clrwr_addr3_b", rdata_b[1], 32'h0);
        check("clrwr_drop_gone", 32'(drop_a), 32'h0);

        // Mid-operation reset, with a write in the reset cycle.
        wen = 1'b1; waddr = 5'd9; wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        wen = 1'b0; raddr[0] = 5'd9; raddr[1] = 5'd9;
        #1;
        check("fill9_a", rdata_a[0], 32'h55AA55AA);
        rst = 1'b1; wen = 1'b1; waddr = 5'd12; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy_a), 32'h1);
        check("midrst_drop", 32'(drop_a), 32'h0);
        check("midrst_rdata_b", rdata_b[0], 32'h0);
        rst = 1'b0; wen = 1'b0;
        run_clear(-1, busy_n, drop_n, drop_at);
        check("midrst_cycles", 32'(busy_n), 32'd32);
        raddr[0] = 5'd9; raddr[1] = 5'd12;
        #1;
        check("midrst_addr9_a", rdata_a[0], 32'h0);
        check("midrst_addr12_a", rdata_a[1], 32'h0);
        @(posedge clk); #1;
        check("midrst_addr9_b", rdata_b[0], 32'h0);
        check("midrst_addr12_b", rdata_b[1], 32'h0);

        // Wide configuration against the reference model.
        c_rst = 1'b0;
        c_busy_n = 0;
        for (int k = 0; k < 300; k++) begin
            if (!c_busy) break;
            c_busy_n++;
            @(posedge clk); #1;
        end
        check("c_init_cycles", 32'(c_busy_n), 32'd64);
        for (int e = 0; e < 64; e++) ref_c[e] = 16'h0;

        for (int k = 0; k < 80; k++) begin
            c_wen   = 1'($urandom_range(0, 1));
            c_waddr = (k % 9 == 0) ? 6'd0 : ((k % 11 == 0) ? 6'd63 : 6'($urandom_range(0, 63)));
            c_wdata = 16'($urandom);
            for (int p = 0; p < 4; p++) begin
                case ($urandom_range(0, 4))
                    0:       c_raddr[p] = c_waddr;
                    1:       c_raddr[p] = 6'd0;
                    default: c_raddr[p] = 6'($urandom_range(0, 63));
                endcase
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                if (c_raddr[p] == 6'd0)                   exp_c = 16'h0;
                else if (c_wen && c_raddr[p] == c_waddr)  exp_c = c_wdata;
                else                                      exp_c = ref_c[c_raddr[p]];
                check($sformatf("c_k%0d_p%0d", k, p), 32'(c_rdata[p]), 32'(exp_c));
            end
            @(posedge clk); #1;
            if (c_wen && c_waddr != 6'd0) ref_c[c_waddr] = c_wdata;
            check($sformatf("c_k%0d_drop", k), 32'(c_drop), 32'h0);
        end
        c_wen = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
